// File: rtl/risc16_io_pkg.sv
// Shared address map, STATUS bit layout and UART serializer states for the
// risc16 data-side I/O slice.
package risc16_io_pkg;

  localparam logic [15:0] ADDR_TXDATA = 16'hFF00;
  localparam logic [15:0] ADDR_STATUS = 16'hFF02;
  localparam logic [15:0] ADDR_CYCLES = 16'hFF04;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_FULL  = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/risc16_uart_tx.sv
// UART transmitter: small TX FIFO feeding an 8N1 serializer, LSB first.
// Bit timing comes from a down-counter reloaded with CLK_DIV-1; a bit ends
// when the counter reaches zero.
//
//  state | meaning
//  IDLE  | line high, pops the FIFO head when the FIFO is non-empty
//  START | start bit, line low for CLK_DIV cycles
//  DATA  | 8 data bits, LSB first, CLK_DIV cycles each
//  STOP  | stop bit, line high for CLK_DIV cycles
module risc16_uart_tx
  import risc16_io_pkg::*;
#(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       clr_ovf,
  output logic       txd,
  output logic       busy,
  output logic       empty,
  output logic       full,
  output logic       ovf
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(FIFO_DEPTH);
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  uart_state_t   state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          push_ok;
  logic          pop;
  logic          baud_tc;

  // full/empty come from the registered count, so a push into a full FIFO is
  // dropped even when the serializer pops in the same cycle
  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign busy    = (state != IDLE);
  assign push_ok = push && !full;
  assign pop     = (state == IDLE) && !empty;
  assign baud_tc = (baud_cnt == '0);

  // FIFO storage, no reset needed: entries are only read once counted in
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_data;
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (push && full) ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  // serializer FSM with registered line output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      txd       <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            shift_reg <= fifo_mem[rd_ptr];
            baud_cnt  <= BAUD_LAST;
            txd       <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (baud_tc) begin
            txd       <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_cnt   <= '0;
            baud_cnt  <= BAUD_LAST;
            state     <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        DATA: begin
          if (baud_tc) begin
            baud_cnt <= BAUD_LAST;
            if (bit_cnt == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              txd       <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        STOP: begin
          if (baud_tc) state <= IDLE;
          else         baud_cnt <= baud_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/risc16_dbus_io.sv
// Data-side memory system for the risc16f core: word RAM, UART TX registers
// and a free-running cycle counter. Reads are combinational so the core can
// sample cpu_ddin in the load cycle.
module risc16_dbus_io
  import risc16_io_pkg::*;
#(
  parameter int RAM_WORDS  = 1024,
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_daddr,
  input  logic [15:0] cpu_ddout,
  input  logic        cpu_doe,
  input  logic        cpu_dwe,
  output logic [15:0] cpu_ddin,
  output logic        uart_txd
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [15:0]   ram [RAM_WORDS];
  logic [15:0]   waddr;
  logic [AW-1:0] ram_idx;
  logic          sel_ram;
  logic          sel_tx;
  logic          sel_stat;
  logic          sel_cyc;
  logic [15:0]   cycles;
  logic [15:0]   status;
  logic          tx_busy;
  logic          tx_empty;
  logic          tx_full;
  logic          tx_ovf;

  // byte address with bit 0 forced low; everything decodes on word addresses
  assign waddr    = cpu_daddr & 16'hFFFE;
  assign ram_idx  = waddr[AW:1];
  assign sel_ram  = !waddr[15];
  assign sel_tx   = (waddr == ADDR_TXDATA);
  assign sel_stat = (waddr == ADDR_STATUS);
  assign sel_cyc  = (waddr == ADDR_CYCLES);

  risc16_uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_uart_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cpu_dwe && sel_tx),
    .push_data (cpu_ddout[7:0]),
    .clr_ovf   (cpu_dwe && sel_stat),
    .txd       (uart_txd),
    .busy      (tx_busy),
    .empty     (tx_empty),
    .full      (tx_full),
    .ovf       (tx_ovf)
  );

  // word RAM, deliberately unreset
  always_ff @(posedge clk) begin
    if (cpu_dwe && sel_ram) ram[ram_idx] <= cpu_ddout;
  end

  // cycle counter; a store wins over the increment for that cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cycles <= '0;
    else if (cpu_dwe && sel_cyc) cycles <= cpu_ddout;
    else                         cycles <= cycles + 1'b1;
  end

  // STATUS word assembled from the transmitter flags
  always_comb begin
    status             = '0;
    status[STAT_BUSY]  = tx_busy;
    status[STAT_EMPTY] = tx_empty;
    status[STAT_FULL]  = tx_full;
    status[STAT_OVF]   = tx_ovf;
  end

  // read mux; pre-write values are returned when a store hits the same cycle
  always_comb begin
    cpu_ddin = '0;
    if (cpu_doe) begin
      if (sel_ram)       cpu_ddin = ram[ram_idx];
      else if (sel_stat) cpu_ddin = status;
      else if (sel_cyc)  cpu_ddin = cycles;
    end
  end

endmodule

// File: tb/tb_risc16_dbus_io.sv
// Bench for risc16_dbus_io: directed CPU accesses plus a UART line monitor
// that decodes frames and checks them against a byte scoreboard.
module tb_risc16_dbus_io;

  localparam int RAM_WORDS  = 1024;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int BIT_NS     = CLK_DIV * 10;

  localparam logic [15:0] A_TX  = 16'hFF00;
  localparam logic [15:0] A_ST  = 16'hFF02;
  localparam logic [15:0] A_CYC = 16'hFF04;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_daddr = '0;
  logic [15:0] cpu_ddout = '0;
  logic        cpu_doe = 1'b0;
  logic        cpu_dwe = 1'b0;
  logic [15:0] cpu_ddin;
  logic        uart_txd;

  int total = 0;
  int bad = 0;
  int frames = 0;
  int rst_evts = 0;
  int txd_falls = 0;
  logic [7:0] sb[$];

  risc16_dbus_io #(
    .RAM_WORDS  (RAM_WORDS),
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_daddr (cpu_daddr),
    .cpu_ddout (cpu_ddout),
    .cpu_doe   (cpu_doe),
    .cpu_dwe   (cpu_dwe),
    .cpu_ddin  (cpu_ddin),
    .uart_txd  (uart_txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    cpu_daddr = a;
    cpu_ddout = d;
    cpu_doe   = 1'b0;
    cpu_dwe   = 1'b1;
    @(posedge clk);
    #1;
    cpu_dwe = 1'b0;
  endtask

  task automatic cpu_rd(input logic [15:0] a, output logic [15:0] q);
    @(negedge clk);
    cpu_daddr = a;
    cpu_dwe   = 1'b0;
    cpu_doe   = 1'b1;
    #1;
    q = cpu_ddin;
    @(posedge clk);
    #1;
    cpu_doe = 1'b0;
  endtask

  task automatic cpu_rw(input logic [15:0] a, input logic [15:0] d, output logic [15:0] q);
    @(negedge clk);
    cpu_daddr = a;
    cpu_ddout = d;
    cpu_doe   = 1'b1;
    cpu_dwe   = 1'b1;
    #1;
    q = cpu_ddin;
    @(posedge clk);
    #1;
    cpu_doe = 1'b0;
    cpu_dwe = 1'b0;
  endtask

  task automatic tx_store(input logic [7:0] b, input bit accepted);
    if (accepted) sb.push_back(b);
    cpu_wr(A_TX, {8'h00, b});
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", 16'(sb.size()), 16'h0000);
    repeat (12) @(posedge clk);
  endtask

  always @(negedge rst_n) rst_evts++;
  always @(negedge uart_txd) if (rst_n === 1'b1) txd_falls++;

  // line monitor: samples each bit mid-period; frames cut by reset are discarded
  initial begin : uart_mon
    logic [7:0] b;
    logic       start_bit;
    logic       stop_bit;
    int         evt;
    forever begin
      @(negedge uart_txd);
      if (rst_n !== 1'b1) continue;
      evt = rst_evts;
      #(BIT_NS / 2 + 2);
      start_bit = uart_txd;
      for (int i = 0; i < 8; i++) begin
        #(BIT_NS);
        b[i] = uart_txd;
      end
      #(BIT_NS);
      stop_bit = uart_txd;
      if (evt == rst_evts) begin
        frames++;
        chk("frame_start", {15'b0, start_bit}, 16'h0000);
        chk("frame_stop", {15'b0, stop_bit}, 16'h0001);
        if (sb.size() == 0) chk("frame_unexpected", 16'(sb.size()), 16'h0001);
        else                chk("frame_data", {8'h00, b}, {8'h00, sb.pop_front()});
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin : main
    logic [15:0] q;
    logic [15:0] exp_st;
    logic        exp_txd;
    logic [7:0]  pat_byte;
    int          k;
    int          f0;

    // reset state, reads are live while reset is held
    repeat (3) @(posedge clk);
    chk("rst_txd", {15'b0, uart_txd}, 16'h0001);
    cpu_rd(A_ST, q);
    chk("rst_status", q, 16'h0002);
    cpu_rd(A_CYC, q);
    chk("rst_cycles", q, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // RAM store/load and aliasing
    cpu_wr(16'h0100, 16'hBEEF);
    cpu_rd(16'h0100, q);
    chk("ram_rd", q, 16'hBEEF);
    cpu_rd(16'h0900, q);
    chk("ram_alias", q, 16'hBEEF);
    cpu_rd(16'h0101, q);
    chk("ram_odd_byte", q, 16'hBEEF);

    // simultaneous read and write returns the old word
    cpu_wr(16'h0010, 16'h1234);
    cpu_rw(16'h0010, 16'h5678, q);
    chk("rw_old", q, 16'h1234);
    cpu_rd(16'h0010, q);
    chk("rw_new", q, 16'h5678);

    // no read strobe -> zero
    @(negedge clk);
    cpu_daddr = 16'h0100;
    cpu_doe   = 1'b0;
    #1;
    chk("doe_low", cpu_ddin, 16'h0000);

    // unmapped space
    cpu_wr(16'h0000, 16'h1111);
    cpu_rd(16'h8000, q);
    chk("unmapped_8000", q, 16'h0000);
    cpu_rd(16'hFF06, q);
    chk("unmapped_ff06", q, 16'h0000);
    cpu_wr(16'h8000, 16'h9999);
    cpu_rd(16'h0000, q);
    chk("unmapped_wr_ram0", q, 16'h1111);
    cpu_rd(16'h8000, q);
    chk("unmapped_8000_after", q, 16'h0000);
    cpu_rd(A_TX, q);
    chk("txdata_rd", q, 16'h0000);

    // cycle counter load and wrap
    cpu_wr(A_CYC, 16'hFFFE);
    cpu_rd(A_CYC, q);
    chk("cyc_loaded", q, 16'hFFFE);
    cpu_rd(A_CYC, q);
    chk("cyc_plus1", q, 16'hFFFF);
    cpu_rd(A_CYC, q);
    chk("cyc_wrap", q, 16'h0000);

    // single frame, cycle-exact line and STATUS
    pat_byte = 8'h55;
    tx_store(pat_byte, 1'b1);
    for (int i = 0; i <= 41; i++) begin
      @(negedge clk);
      cpu_daddr = A_ST;
      cpu_doe   = 1'b1;
      #1;
      if (i == 0 || i == 41) begin
        exp_txd = 1'b1;
      end else begin
        k = (i - 1) / 4;
        if (k == 0)      exp_txd = 1'b0;
        else if (k == 9) exp_txd = 1'b1;
        else             exp_txd = pat_byte[k-1];
      end
      if (i == 0)       exp_st = 16'h0000;
      else if (i == 41) exp_st = 16'h0002;
      else              exp_st = 16'h0003;
      chk($sformatf("frame_txd[%0d]", i), {15'b0, uart_txd}, {15'b0, exp_txd});
      chk($sformatf("frame_status[%0d]", i), cpu_ddin, exp_st);
      @(posedge clk);
      #1;
      cpu_doe = 1'b0;
    end
    wait_drain(100);

    // FIFO fill, overflow and clear
    f0 = frames;
    tx_store(8'hA0, 1'b1);
    repeat (2) @(posedge clk);
    tx_store(8'hA1, 1'b1);
    tx_store(8'hA2, 1'b1);
    tx_store(8'hA3, 1'b1);
    tx_store(8'hA4, 1'b1);
    cpu_rd(A_ST, q);
    chk("fifo_full", q, 16'h0005);
    tx_store(8'hA5, 1'b0);
    cpu_rd(A_ST, q);
    chk("fifo_ovf", q, 16'h000D);
    wait_drain(400);
    chk("ovf_frames", 16'(frames - f0), 16'd5);
    cpu_rd(A_ST, q);
    chk("ovf_sticky", q, 16'h000A);
    cpu_wr(A_ST, 16'h0000);
    cpu_rd(A_ST, q);
    chk("ovf_cleared", q, 16'h0002);

    // reset in the middle of a data bit
    tx_store(8'h00, 1'b1);
    tx_store(8'h3C, 1'b1);
    repeat (8) @(posedge clk);
    #3;
    chk("pre_rst_txd", {15'b0, uart_txd}, 16'h0000);
    rst_n = 1'b0;
    #1;
    chk("rst_async_txd", {15'b0, uart_txd}, 16'h0001);
    sb.delete();
    f0 = txd_falls;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cpu_rd(A_ST, q);
    chk("post_rst_status", q, 16'h0002);
    repeat (100) @(posedge clk);
    chk("post_rst_no_frame", 16'(txd_falls - f0), 16'h0000);
    chk("post_rst_txd", {15'b0, uart_txd}, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
